// File: rtl/gb_cpu_pkg.sv
// Shared CPU definitions: register selector encoding, reset values and the
// register-file state record with its write helper.
package gb_cpu_pkg;

  localparam logic [3:0] SEL_B  = 4'd0;
  localparam logic [3:0] SEL_C  = 4'd1;
  localparam logic [3:0] SEL_D  = 4'd2;
  localparam logic [3:0] SEL_E  = 4'd3;
  localparam logic [3:0] SEL_H  = 4'd4;
  localparam logic [3:0] SEL_L  = 4'd5;
  localparam logic [3:0] SEL_F  = 4'd6;
  localparam logic [3:0] SEL_A  = 4'd7;
  localparam logic [3:0] SEL_BC = 4'd8;
  localparam logic [3:0] SEL_DE = 4'd9;
  localparam logic [3:0] SEL_HL = 4'd10;
  localparam logic [3:0] SEL_SP = 4'd11;
  localparam logic [3:0] SEL_AF = 4'd12;
  localparam logic [3:0] SEL_PC = 4'd13;

  localparam logic [15:0] SP_RESET = 16'hFFFE;
  localparam logic [15:0] PC_RESET = 16'h0000;
  // The low nibble of F does not exist in hardware; every write path masks it.
  localparam logic [7:0]  F_MASK   = 8'hF0;

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  f;
    logic [7:0]  b;
    logic [7:0]  c;
    logic [7:0]  d;
    logic [7:0]  e;
    logic [7:0]  h;
    logic [7:0]  l;
    logic [15:0] sp;
    logic [15:0] pc;
  } regs_t;

  localparam regs_t REGS_RESET = '{
    a: 8'h00, f: 8'h00, b: 8'h00, c: 8'h00, d: 8'h00, e: 8'h00,
    h: 8'h00, l: 8'h00, sp: SP_RESET, pc: PC_RESET
  };

  // Overwrites only the bytes covered by sel; reserved selectors are no-ops.
  function automatic regs_t write_sel(regs_t r, logic [3:0] sel, logic [15:0] data);
    regs_t w;
    w = r;
    case (sel)
      SEL_B:   w.b = data[7:0];
      SEL_C:   w.c = data[7:0];
      SEL_D:   w.d = data[7:0];
      SEL_E:   w.e = data[7:0];
      SEL_H:   w.h = data[7:0];
      SEL_L:   w.l = data[7:0];
      SEL_F:   w.f = data[7:0] & F_MASK;
      SEL_A:   w.a = data[7:0];
      SEL_BC:  begin w.b = data[15:8]; w.c = data[7:0]; end
      SEL_DE:  begin w.d = data[15:8]; w.e = data[7:0]; end
      SEL_HL:  begin w.h = data[15:8]; w.l = data[7:0]; end
      SEL_SP:  w.sp = data;
      SEL_AF:  begin w.a = data[15:8]; w.f = data[7:0] & F_MASK; end
      SEL_PC:  w.pc = data;
      default: ;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/regfile_read_mux.sv
// One register-file read port: selects an 8-bit (zero-extended) or 16-bit
// value from the supplied register state.
module regfile_read_mux
  import gb_cpu_pkg::*;
(
  input  regs_t       regs,
  input  logic [3:0]  sel,
  output logic [15:0] data
);

  always_comb begin
    case (sel)
      SEL_B:   data = {8'h00, regs.b};
      SEL_C:   data = {8'h00, regs.c};
      SEL_D:   data = {8'h00, regs.d};
      SEL_E:   data = {8'h00, regs.e};
      SEL_H:   data = {8'h00, regs.h};
      SEL_L:   data = {8'h00, regs.l};
      SEL_F:   data = {8'h00, regs.f};
      SEL_A:   data = {8'h00, regs.a};
      SEL_BC:  data = {regs.b, regs.c};
      SEL_DE:  data = {regs.d, regs.e};
      SEL_HL:  data = {regs.h, regs.l};
      SEL_SP:  data = regs.sp;
      SEL_AF:  data = {regs.a, regs.f};
      SEL_PC:  data = regs.pc;
      default: data = 16'h0000;
    endcase
  end

endmodule

// File: rtl/cpu_regfile.sv
// CPU register file (A F B C D E H L SP PC) with two read ports, two write
// ports, flag write-back and PC/SP stepping. Define CPU_REGFILE_BYPASS_EN to
// forward same-cycle writes to the x/y read ports.
module cpu_regfile
  import gb_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  rdx_sel,
  input  logic [3:0]  rdy_sel,
  output logic [15:0] x,
  output logic [15:0] y,
  input  logic        wr_en,
  input  logic [3:0]  wr_sel,
  input  logic [15:0] wr_data,
  input  logic        alu_wb_en,
  input  logic [3:0]  alu_wb_sel,
  input  logic [15:0] alu_result,
  input  logic        flags_wb_en,
  input  logic [7:0]  alu_flags,
  input  logic        pc_inc,
  input  logic        sp_inc,
  input  logic        sp_dec,
  output logic [15:0] pc,
  output logic [15:0] sp,
  output logic [7:0]  flags
);

  regs_t cur;
  regs_t nxt;
  regs_t rd_src;

  // Sources are applied lowest priority first so later assignments win per
  // byte. A port write to PC/SP covers both bytes, so it also suppresses the
  // concurrent step for that register.
  // NOTE: nxt starts from cur so every path assigns it and no latch is inferred.
  always_comb begin
    nxt = cur;
    if (pc_inc) nxt.pc = cur.pc + 16'd1;
    if (sp_inc && !sp_dec)      nxt.sp = cur.sp + 16'd1;
    else if (sp_dec && !sp_inc) nxt.sp = cur.sp - 16'd1;
    if (flags_wb_en) nxt.f = alu_flags & F_MASK;
    if (alu_wb_en)   nxt = write_sel(nxt, alu_wb_sel, alu_result);
    if (wr_en)       nxt = write_sel(nxt, wr_sel, wr_data);
  end

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the pre-edge value of nxt.
  always_ff @(posedge clk) begin
    if (reset) cur <= REGS_RESET;
    else       cur <= nxt;
  end

`ifdef CPU_REGFILE_BYPASS_EN
  assign rd_src = nxt;
`else
  assign rd_src = cur;
`endif

  regfile_read_mux u_read_x (
    .regs (rd_src),
    .sel  (rdx_sel),
    .data (x)
  );

  regfile_read_mux u_read_y (
    .regs (rd_src),
    .sel  (rdy_sel),
    .data (y)
  );

  assign pc    = cur.pc;
  assign sp    = cur.sp;
  assign flags = cur.f;

endmodule

// File: doc/cpu_regfile.md
CPU_REGFILE -- requirements
Module: cpu_regfile

Interface
REQ-001 SHALL have clock and reset: reset, synchronous, active-high; clock clk.
REQ-002 SHALL have ports:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- rdx_sel  in  4  X read selector
- rdy_sel  in  4  Y read selector
- x  out  16  X operand to ALU, zero-extended for 8-bit selectors
- y  out  16  Y operand to ALU, zero-extended for 8-bit selectors
- wr_en  in  1  general write strobe
- wr_sel  in  4  general write selector
- wr_data  in  16  general write data; low byte used for 8-bit selectors
- alu_wb_en  in  1  ALU result write-back strobe
- alu_wb_sel  in  4  ALU result destination
- alu_result  in  16  ALU result (ALU A output)
- flags_wb_en  in  1  ALU flag write-back strobe
- alu_flags  in  8  ALU flags
- pc_inc  in  1  PC += 1
- sp_inc  in  1  SP += 1
- sp_dec  in  1  SP -= 1
- pc  out  16  current PC
- sp  out  16  current SP
- flags  out  8  current F

Function
REQ-003 SHALL use the selector encoding:
- 0 B, 1 C, 2 D, 3 E, 4 H, 5 L, 6 F, 7 A (8-bit)
- 8 BC, 9 DE, 10 HL, 11 SP, 12 AF, 13 PC (16-bit, high byte first register)
- 14, 15 reserved: read 0, writes ignored
REQ-004 SHALL drive reads combinationally from registered state; writes SHALL become visible the cycle after the strobe.
REQ-005 SHALL force F[3:0] to 0 on every write path; F[3:0] SHALL always read 0.
REQ-006 SHALL resolve writes to a byte in one cycle with this priority: wr_en port > alu_wb_en port > flags_wb_en (F only) > pc_inc / sp_inc / sp_dec.
- Priority SHALL be resolved per byte: a 16-bit write SHALL override only the bytes it covers.
REQ-007 SHALL ignore pc_inc when either write port targets PC that cycle.
- SHALL likewise ignore sp_inc/sp_dec when either write port targets SP.
REQ-008 SHALL leave SP unchanged when sp_inc and sp_dec are asserted together.
REQ-009 SHALL wrap PC and SP modulo 2^16: FFFF+1=0000, 0000-1=FFFF.
REQ-010 SHALL let both read ports select the same register with identical results.
REQ-011 SHALL drive pc, sp and flags continuously from registered state, independent of the read selectors.

Reset
REQ-012 SHALL on reset set A,F,B,C,D,E,H,L to 00, SP to FFFE and PC to 0000.
- pc, sp and flags SHALL read 0000, FFFE and 00 the cycle after reset.
REQ-013 SHALL give reset priority over every strobe in the same cycle; a write coincident with reset SHALL be lost.

Configuration
REQ-014 SHALL support macro CPU_REGFILE_BYPASS_EN.
- Defined: x and y SHALL return the post-write next-state value, i.e. same-cycle forwarding of all write sources with REQ-006 priority.
- Undefined: x and y SHALL return current registered state per REQ-004.
- flags, pc and sp SHALL be registered state in both builds.

Structure
REQ-015 SHALL place the selector encoding constants and the reset-value constants (SP_RESET=FFFE, PC_RESET=0000) in shared package gb_cpu_pkg.
REQ-016 SHALL implement the read mux as sub-module regfile_read_mux, instantiated twice (X, Y).

Verification
REQ-017 Bench SHALL cover:
- Reset, then read all selectors 0-15 -> 0 everywhere except sp=FFFE, rdx_sel=11 gives FFFE, pc=0000.
- wr_en sel=8 data=1234, next cycle rdx_sel=0 -> 0012, rdy_sel=1 -> 0034, rdx_sel=8 -> 1234.
- wr_en sel=12 data=ABCD -> AF reads AB C0, flags=C0.
- wr_en sel=7 data=0011, alu_wb_en sel=7 result=0022 and flags_wb_en alu_flags=F0 in the same cycle -> A=11, F=F0.
- SP=0000, sp_dec -> FFFF; then sp_inc+sp_dec -> FFFF; PC=FFFF, pc_inc -> 0000; pc_inc with wr_en sel=13 data=0100 -> 0100.
- With CPU_REGFILE_BYPASS_EN: wr_en sel=9 data=BEEF, rdx_sel=9 same cycle -> x=BEEF. Without it: x=old DE, BEEF next cycle.
